// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// HLT/NOP constants and the opcode field location.
package fetch_pkg;

  typedef logic [15:0] word_t;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] HLT_OPCODE = 4'hF;
  localparam word_t      NOP_INSTR  = 16'h0000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic [3:0] opcode_of(input word_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Architectural program counter: 16-bit register with write enable,
// asynchronously reset to RESET_PC.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem request and
// decides what is written into IF/ID each cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | fetching, one word per cycle on a hit
// ST_MISS | waiting on imem; redirects are parked in pend_pc until data
// ST_HALT | HLT fetched; request idle until a redirect or reset
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = fetch_pkg::HLT_OPCODE,
  parameter logic [15:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus_two,
  output logic [15:0] ifid_instr,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        halted
);

  import fetch_pkg::*;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        run_en;
  logic        pend_valid;
  logic [15:0] pend_pc;
  logic        pend_set;
  logic        pend_clr;
  logic        pc_we;
  logic [15:0] pc_nxt;
  logic [15:0] redirect_pc_al;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .we  (pc_we),
    .d   (pc_nxt),
    .q   (pc_out)
  );

  assign redirect_pc_al = {redirect_pc[15:1], 1'b0};
  assign pc_plus_two    = pc_out + 16'h0002;
  assign imem_addr      = pc_out;
  assign halted         = (state == ST_HALT);

  // run_en holds everything quiet until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      run_en     <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
    end else begin
      run_en <= 1'b1;
      state  <= state_nxt;
      if (pend_clr) begin
        pend_valid <= 1'b0;
      end else if (pend_set) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc_al;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_we      = 1'b0;
    pc_nxt     = pc_plus_two;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    imem_req   = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    ifid_instr = NOP_INSTR;
    if (run_en) begin
      case (state)
        ST_HALT: begin
          if (redirect) begin
            pc_we      = 1'b1;
            pc_nxt     = redirect_pc_al;
            ifid_flush = 1'b1;
            state_nxt  = ST_RUN;
          end
        end
        default: begin
          imem_req = 1'b1;
          if (redirect && (state != ST_MISS || imem_rdy)) begin
            pc_we      = 1'b1;
            pc_nxt     = redirect_pc_al;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            pend_clr   = 1'b1;
            state_nxt  = ST_RUN;
          end else if (state == ST_MISS && !imem_rdy) begin
            // address must stay stable while imem is busy, so park the target
            pend_set   = redirect;
            ifid_we    = !stall;
            ifid_flush = !stall;
          end else if (state == ST_MISS && pend_valid) begin
            pc_we      = 1'b1;
            pc_nxt     = pend_pc;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            pend_clr   = 1'b1;
            state_nxt  = ST_RUN;
          end else if (stall) begin
            state_nxt = ST_RUN;
          end else if (!imem_rdy) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_nxt  = ST_MISS;
          end else if (opcode_of(imem_data) == HLT_OPCODE) begin
            ifid_instr = imem_data;
            ifid_we    = 1'b1;
            state_nxt  = ST_HALT;
          end else begin
            ifid_instr = imem_data;
            ifid_we    = 1'b1;
            pc_we      = 1'b1;
            state_nxt  = ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural fetch model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc_out;
  logic [15:0] pc_plus_two;
  logic [15:0] ifid_instr;
  logic        ifid_we;
  logic        ifid_flush;
  logic        halted;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .pc_out      (pc_out),
    .pc_plus_two (pc_plus_two),
    .ifid_instr  (ifid_instr),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: what the fetch unit has "seen" so far
  logic [15:0] m_pc, m_pend_pc, n_pc, n_pend_pc;
  bit          m_started, m_halted, m_waiting, m_pend;
  bit          n_started, n_halted, n_waiting, n_pend;
  logic        e_req, e_we, e_flush;
  logic [15:0] e_instr;

  task automatic model_reset();
    m_pc = 16'h0000; m_pend_pc = 16'h0000;
    m_started = 0; m_halted = 0; m_waiting = 0; m_pend = 0;
  endtask

  task automatic model_eval();
    logic [15:0] tgt;
    tgt = redirect_pc & 16'hFFFE;
    n_pc = m_pc; n_pend_pc = m_pend_pc;
    n_started = 1; n_halted = m_halted; n_waiting = m_waiting; n_pend = m_pend;
    e_req = 0; e_we = 0; e_flush = 0; e_instr = 16'h0000;
    if (!m_started) begin
      n_started = 1;
    end else if (m_halted) begin
      if (redirect) begin
        n_pc = tgt; e_flush = 1; n_halted = 0;
      end
    end else begin
      e_req = 1;
      if (redirect && (!m_waiting || imem_rdy)) begin
        n_pc = tgt; e_we = 1; e_flush = 1; n_waiting = 0; n_pend = 0;
      end else if (m_waiting && !imem_rdy) begin
        if (redirect) begin n_pend = 1; n_pend_pc = tgt; end
        e_we = !stall; e_flush = !stall;
      end else if (m_waiting && m_pend) begin
        n_pc = m_pend_pc; e_we = 1; e_flush = 1; n_waiting = 0; n_pend = 0;
      end else if (stall) begin
        n_waiting = 0;
      end else if (!imem_rdy) begin
        e_we = 1; e_flush = 1; n_waiting = 1;
      end else if (imem_data[15:12] == 4'hF) begin
        e_instr = imem_data; e_we = 1; n_halted = 1; n_waiting = 0;
      end else begin
        e_instr = imem_data; e_we = 1; n_pc = m_pc + 16'd2; n_waiting = 0;
      end
    end
  endtask

  task automatic model_commit();
    m_pc = n_pc; m_pend_pc = n_pend_pc; m_started = n_started;
    m_halted = n_halted; m_waiting = n_waiting; m_pend = n_pend;
  endtask

  task automatic apply_in(input logic st, input logic rd, input logic [15:0] rpc,
                          input logic rdy, input logic [15:0] data);
    stall = st; redirect = rd; redirect_pc = rpc; imem_rdy = rdy; imem_data = data;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [15:0] plain_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 14));
    return {op, 12'($urandom)};
  endfunction

  task automatic run_fetches(input int n);
    for (int i = 0; i < n; i++) begin
      apply_in(0, 0, 16'h0000, 1, plain_word());
      step();
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1;
    apply_in(0, 0, 16'h0000, 0, 16'h0000);
    repeat (2) @(negedge clk);
    n_checks++; if (pc_out !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", pc_out); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", imem_req); else n_pass++;
    n_checks++; if (ifid_we !== 1'b0 || ifid_flush !== 1'b0) $display("FAIL reset_we_flush got %b%b exp 00", ifid_we, ifid_flush); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else n_pass++;
    n_checks++; if (ifid_instr !== 16'h0000) $display("FAIL reset_instr got %h exp 0000", ifid_instr); else n_pass++;
    rst = 0;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL req_before_edge got %b exp 0", imem_req); else n_pass++;
    step();
    n_checks++; if (imem_req !== 1'b1) $display("FAIL req_after_edge got %b exp 1", imem_req); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = plain_word();
      apply_in(0, 0, 16'h0000, 1, w);
      @(negedge clk);
      n_checks++; if (pc_out !== 16'(2 * i)) $display("FAIL seq_pc got %h exp %h", pc_out, 16'(2 * i)); else n_pass++;
      n_checks++; if (pc_plus_two !== 16'(2 * i + 2)) $display("FAIL seq_pc2 got %h exp %h", pc_plus_two, 16'(2 * i + 2)); else n_pass++;
      n_checks++; if (ifid_we !== 1'b1 || ifid_instr !== w) $display("FAIL seq_write got we=%b %h exp we=1 %h", ifid_we, ifid_instr, w); else n_pass++;
      step();
    end
  endtask

  task automatic test_redirect_stall();
    run_fetches(4);
    n_checks++; if (pc_out !== 16'h0010) $display("FAIL rs_start_pc got %h exp 0010", pc_out); else n_pass++;
    apply_in(1, 1, 16'h0041, 1'($urandom), plain_word());
    @(negedge clk);
    n_checks++; if (ifid_flush !== 1'b1 || ifid_we !== 1'b1) $display("FAIL rs_flush got we=%b fl=%b exp 1 1", ifid_we, ifid_flush); else n_pass++;
    n_checks++; if (ifid_instr !== 16'h0000) $display("FAIL rs_instr got %h exp 0000", ifid_instr); else n_pass++;
    step();
    n_checks++; if (pc_out !== 16'h0040) $display("FAIL rs_target got %h exp 0040", pc_out); else n_pass++;
  endtask

  task automatic test_miss_redirect();
    apply_in(0, 1, 16'h0020, 1, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) begin
      apply_in(0, (i == 1), 16'h0100, 0, 16'($urandom));
      @(negedge clk);
      n_checks++; if (pc_out !== 16'h0020 || imem_addr !== 16'h0020) $display("FAIL miss_pc wait %0d got %h/%h exp 0020", i, pc_out, imem_addr); else n_pass++;
      n_checks++; if (ifid_we !== 1'b1 || ifid_flush !== 1'b1 || imem_req !== 1'b1) $display("FAIL miss_bubble wait %0d got we=%b fl=%b req=%b exp 1 1 1", i, ifid_we, ifid_flush, imem_req); else n_pass++;
      step();
    end
    apply_in(0, 0, 16'h0000, 1, 16'hF123);
    @(negedge clk);
    n_checks++; if (ifid_flush !== 1'b1 || ifid_instr !== 16'h0000) $display("FAIL miss_discard got fl=%b %h exp 1 0000", ifid_flush, ifid_instr); else n_pass++;
    step();
    n_checks++; if (pc_out !== 16'h0100 || halted !== 1'b0) $display("FAIL miss_target got %h h=%b exp 0100 h=0", pc_out, halted); else n_pass++;
    apply_in(0, 0, 16'h0000, 1, 16'h1234);
    @(negedge clk);
    n_checks++; if (ifid_instr !== 16'h1234 || ifid_flush !== 1'b0) $display("FAIL miss_resume got %h fl=%b exp 1234 0", ifid_instr, ifid_flush); else n_pass++;
    step();
  endtask

  task automatic test_halt();
    apply_in(0, 1, 16'h0030, 1, 16'h0000);
    step();
    apply_in(0, 0, 16'h0000, 1, 16'hF000);
    @(negedge clk);
    n_checks++; if (ifid_instr !== 16'hF000 || ifid_we !== 1'b1 || halted !== 1'b0) $display("FAIL hlt_write got %h we=%b h=%b exp F000 1 0", ifid_instr, ifid_we, halted); else n_pass++;
    step();
    for (int i = 0; i < 10; i++) begin
      apply_in(1'($urandom), 0, 16'($urandom), 1'($urandom), 16'($urandom));
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || ifid_we !== 1'b0 || pc_out !== 16'h0030)
        $display("FAIL hlt_hold cycle %0d got h=%b req=%b we=%b pc=%h exp 1 0 0 0030", i, halted, imem_req, ifid_we, pc_out);
      else n_pass++;
      step();
    end
    apply_in(0, 1, 16'h0050, 1, 16'h0000);
    @(negedge clk);
    n_checks++; if (ifid_flush !== 1'b1) $display("FAIL hlt_exit_flush got %b exp 1", ifid_flush); else n_pass++;
    step();
    n_checks++; if (halted !== 1'b0 || pc_out !== 16'h0050) $display("FAIL hlt_exit got h=%b pc=%h exp 0 0050", halted, pc_out); else n_pass++;
  endtask

  task automatic test_wrap();
    apply_in(0, 1, 16'hFFFE, 1, 16'h0000);
    step();
    apply_in(0, 0, 16'h0000, 1, 16'h1234);
    @(negedge clk);
    n_checks++; if (pc_out !== 16'hFFFE || pc_plus_two !== 16'h0000) $display("FAIL wrap_pc2 got %h/%h exp FFFE/0000", pc_out, pc_plus_two); else n_pass++;
    step();
    n_checks++; if (pc_out !== 16'h0000) $display("FAIL wrap_next got %h exp 0000", pc_out); else n_pass++;
  endtask

  task automatic test_reset_mid_miss();
    logic [15:0] w;
    apply_in(0, 1, 16'h0200, 1, 16'h0000);
    step();
    apply_in(0, 0, 16'h0000, 0, 16'h0000);
    step();
    apply_in(0, 1, 16'h0300, 0, 16'h0000);
    step();
    apply_in(0, 0, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_checks++; if (pc_out !== 16'h0000 || imem_req !== 1'b0) $display("FAIL async_rst got pc=%h req=%b exp 0000 0", pc_out, imem_req); else n_pass++;
    n_checks++; if (ifid_we !== 1'b0 || ifid_flush !== 1'b0 || halted !== 1'b0) $display("FAIL async_rst_ctl got %b%b%b exp 000", ifid_we, ifid_flush, halted); else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 0;
    apply_in(0, 0, 16'h0000, 1, 16'h0000);
    step();
    for (int i = 0; i < 3; i++) begin
      w = plain_word();
      apply_in(0, 0, 16'h0000, 1, w);
      @(negedge clk);
      n_checks++; if (pc_out !== 16'(2 * i) || ifid_instr !== w) $display("FAIL post_rst_fetch %0d got %h %h exp %h %h", i, pc_out, ifid_instr, 16'(2 * i), w); else n_pass++;
      step();
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int c = 0; c < 400; c++) begin
      w = ($urandom_range(0, 15) == 0) ? {4'hF, 12'($urandom)} : plain_word();
      apply_in(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), 16'($urandom),
               ($urandom_range(0, 3) != 0), w);
      @(negedge clk);
      n_checks++; if (pc_out !== m_pc || imem_addr !== m_pc) $display("FAIL rand_pc cycle %0d got %h/%h exp %h", c, pc_out, imem_addr, m_pc); else n_pass++;
      n_checks++; if (pc_plus_two !== 16'(m_pc + 16'd2)) $display("FAIL rand_pc2 cycle %0d got %h exp %h", c, pc_plus_two, 16'(m_pc + 16'd2)); else n_pass++;
      n_checks++; if (imem_req !== e_req) $display("FAIL rand_req cycle %0d got %b exp %b", c, imem_req, e_req); else n_pass++;
      n_checks++; if (ifid_we !== e_we || ifid_flush !== e_flush) $display("FAIL rand_we_flush cycle %0d got %b%b exp %b%b", c, ifid_we, ifid_flush, e_we, e_flush); else n_pass++;
      n_checks++; if (ifid_instr !== e_instr) $display("FAIL rand_instr cycle %0d got %h exp %h", c, ifid_instr, e_instr); else n_pass++;
      n_checks++; if (halted !== m_halted) $display("FAIL rand_halted cycle %0d got %b exp %b", c, halted, m_halted); else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_stall();
    test_miss_redirect();
    test_halt();
    test_wrap();
    test_reset_mid_miss();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
